// File: rtl/cpu_pkg.sv
// cpu_pkg: loader state encoding and shared constants.
// CHK exists only when PROG_LOADER_CHECKSUM_EN is defined.
package cpu_pkg;
  typedef enum logic [2:0] {
    LEN0, LEN1, DATA, WRITE, DONE, ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;
  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam int HDR_LEN = 2;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs four bytes little-endian into a word and flags the 4th byte.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);
  logic [1:0] cnt;
  assign last = en && cnt == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= {din, word[31:8]};
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed word image from a byte stream into program memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  output logic [3:0]            mem_byte_w_en,
  input  logic                  restart,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);
  state_t state, nxt;
  logic live, acc, last, clr, wr;
  logic [31:0] word;
  logic [8*HDR_LEN-1:0] n, n_new, word_idx, idx_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] chk;
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  assign acc      = in_valid && in_ready;
  assign clr      = (state == DONE || state == ERROR) && restart;
  assign n_new    = {in_data, n[7:0]};
  assign idx_inc  = word_idx + 1'b1;
  assign wr       = state == WRITE;
  // in_ready stays low until the first edge after reset release
  assign in_ready = live && state != WRITE && state != DONE && state != ERROR;
  assign mem_byte_w_en = wr ? BE_ALL : 4'b0000;
  assign mem_wr_addr   = wr ? ADDR_WIDTH'({word_idx, 2'b00}) : '0;
  assign mem_wr_data   = wr ? word : '0;
  assign done     = state == DONE;
  assign error    = state == ERROR;
  assign cpu_hold = state != DONE;
  word_assembler u_asm (
    .clk   (sysclk),
    .rst_n (rst),
    .clr   (clr),
    .en    (acc && state == DATA),
    .din   (in_data),
    .word  (word),
    .last  (last)
  );
  always_comb begin
    nxt = state;
    case (state)
      LEN0:  nxt = acc ? LEN1 : LEN0;
      LEN1:  if (acc) nxt = 32'(n_new) > MEM_WORDS ? ERROR : n_new == '0 ? FIN : DATA;
      DATA:  nxt = acc && last ? WRITE : DATA;
      WRITE: nxt = idx_inc == n ? FIN : DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK:   if (acc) nxt = in_data == chk ? DONE : ERROR;
`endif
      DONE, ERROR: nxt = restart ? LEN0 : state;
      default: nxt = LEN0;
    endcase
  end
  always_ff @(posedge sysclk or negedge rst)
    if (!rst) begin
      state <= LEN0;
      live  <= 1'b0;
    end else begin
      state <= nxt;
      live  <= 1'b1;
    end
  always_ff @(posedge sysclk or negedge rst)
    if (!rst) begin
      n        <= '0;
      word_idx <= '0;
    end else if (clr) begin
      n        <= '0;
      word_idx <= '0;
    end else begin
      if (acc && state == LEN0) n[7:0] <= in_data;
      if (acc && state == LEN1) n <= n_new;
      if (wr) word_idx <= idx_inc;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge sysclk or negedge rst)
    if (!rst) chk <= '0;
    else if (clr) chk <= '0;
    else if (acc) chk <= chk ^ in_data;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of header parsing, word writes, errors, reset and restart.
module tb_prog_loader;
  logic        sysclk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_w_en;
  logic        restart = 1'b0;
  logic        cpu_hold, done, error;
  int total = 0, bad = 0, wc = 0;
  logic [31:0] last_data = '0;
  logic [11:0] last_addr = '0;

  prog_loader dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_byte_w_en (mem_byte_w_en),
    .restart       (restart),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .error         (error)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk)
    if (mem_byte_w_en != 4'b0000) begin
      wc++;
      last_addr = mem_wr_addr;
      last_data = mem_wr_data;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_data = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 40) begin
      @(posedge sysclk); #1;
      t++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed in_ready=%b expected=1 byte=%h", in_ready, b);
    end else begin
      @(posedge sysclk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) begin
      @(posedge sysclk); #1;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge sysclk); #1;
    restart = 1'b0;
  endtask

  initial begin
    idle(2);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_we", mem_byte_w_en, 0);
    chk("rst_addr", mem_wr_addr, 0);
    chk("rst_data", mem_wr_data, 0);
    rst = 1'b1;
    idle(1);
    chk("post_rst_ready", in_ready, 1);

    // single word 0x00000013
    send(8'h01); send(8'h00);
    idle(3);
    chk("stall_ready", in_ready, 1);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    chk("w1_we", mem_byte_w_en, 4'hf);
    chk("w1_addr", mem_wr_addr, 0);
    chk("w1_data", mem_wr_data, 32'h00000013);
    chk("w1_ready", in_ready, 0);
    chk("w1_done_early", done, 0);
    idle(1);
    chk("w1_we_after", mem_byte_w_en, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h12);
`endif
    chk("w1_done", done, 1);
    chk("w1_hold", cpu_hold, 0);
    chk("w1_count", wc, 1);
    chk("w1_mon_data", last_data, 32'h00000013);
    idle(3);
    chk("done_stays", done, 1);
    pulse_restart();
    chk("restart_done", done, 0);
    chk("restart_hold", cpu_hold, 1);
    chk("restart_ready", in_ready, 1);

    // two words with gaps; restart in LEN1 must be ignored
    send(8'h02);
    pulse_restart();
    send(8'h00);
    send(8'hEF); idle(2); send(8'hBE); send(8'hAD); idle(1); send(8'hDE);
    chk("w2a_we", mem_byte_w_en, 4'hf);
    chk("w2a_addr", mem_wr_addr, 12'h000);
    chk("w2a_data", mem_wr_data, 32'hDEADBEEF);
    chk("w2a_ready", in_ready, 0);
    send(8'h93); idle(3); send(8'h00); send(8'h10); send(8'h00);
    chk("w2b_we", mem_byte_w_en, 4'hf);
    chk("w2b_addr", mem_wr_addr, 12'h004);
    chk("w2b_data", mem_wr_data, 32'h00100093);
    chk("w2b_ready", in_ready, 0);
    idle(1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'hA3);
`endif
    chk("w2_done", done, 1);
    chk("w2_count", wc, 3);
    chk("w2_mon_addr", last_addr, 12'h004);

    // oversize header N=1025
    pulse_restart();
    send(8'h01); send(8'h04);
    chk("big_error", error, 1);
    chk("big_hold", cpu_hold, 1);
    chk("big_ready", in_ready, 0);
    chk("big_done", done, 0);
    idle(2);
    chk("big_count", wc, 3);

    // reset mid-load, then reload
    pulse_restart();
    chk("err_restart", error, 0);
    send(8'h01); send(8'h00); send(8'h13); send(8'h00);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_we", mem_byte_w_en, 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_count", wc, 3);
    chk("mid_rst_ready2", in_ready, 1);
    send(8'h01); send(8'h00); send(8'h37); send(8'h12); send(8'h00); send(8'h00);
    chk("rl_addr", mem_wr_addr, 12'h000);
    chk("rl_data", mem_wr_data, 32'h00001237);
    idle(1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h24);
`endif
    chk("rl_done", done, 1);
    chk("rl_count", wc, 4);

    // empty image
    pulse_restart();
    send(8'h00); send(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("n0_chk_ready", in_ready, 1);
    chk("n0_chk_done", done, 0);
    send(8'h00);
`endif
    chk("n0_done", done, 1);
    chk("n0_hold", cpu_hold, 0);
    chk("n0_count", wc, 4);

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_restart();
    send(8'h01); send(8'h00); send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    idle(1);
    chk("ck_ready", in_ready, 1);
    send(8'h12);
    chk("ck_good_done", done, 1);
    pulse_restart();
    send(8'h01); send(8'h00); send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    idle(1);
    send(8'h13);
    chk("ck_bad_error", error, 1);
    chk("ck_bad_hold", cpu_hold, 1);
    chk("ck_count", wc, 6);
    pulse_restart();
    chk("ck_restart_ready", in_ready, 1);
    chk("ck_restart_error", error, 0);
    send(8'h00); send(8'h00); send(8'h00);
    chk("ck_reload_done", done, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: program-memory byte-address width.
REQ-002 SHALL have parameter MEM_WORDS, default 1024: capacity in 32-bit words.
REQ-003 SHALL have port sysclk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  8: byte from the serial receiver.
REQ-006 SHALL have port in_valid  input  1: in_data is valid.
REQ-007 SHALL have port in_ready  output  1: loader accepts a byte this cycle.
REQ-008 SHALL have port mem_wr_addr  output  ADDR_WIDTH: program-memory byte write address.
REQ-009 SHALL have port mem_wr_data  output  32: program-memory write word.
REQ-010 SHALL have port mem_byte_w_en  output  4: byte write enables.
REQ-011 SHALL have port restart  input  1: single-cycle request to reload from DONE or ERROR.
REQ-012 SHALL have port cpu_hold  output  1: high holds the CPU core in reset.
REQ-013 SHALL have port done  output  1: image loaded successfully.
REQ-014 SHALL have port error  output  1: load aborted.

Function
REQ-015 SHALL accept a byte only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL run the states LEN0, LEN1, DATA, WRITE, CHK (macro only), DONE and ERROR.
REQ-017 SHALL capture the word count N, little-endian, from byte 0 in LEN0 and byte 1 in LEN1.
REQ-018 SHALL go to ERROR after LEN1 when N > MEM_WORDS.
REQ-019 SHALL, when N=0, go from LEN1 to CHK with the macro defined, or to DONE without it.
REQ-020 SHALL assemble each word little-endian in DATA: the first byte goes to bits [7:0].
REQ-021 SHALL enter WRITE in the cycle after the 4th byte of a word is accepted.
REQ-022 SHALL, in WRITE only, drive mem_byte_w_en=4'b1111, mem_wr_addr=word_idx*4 and mem_wr_data=the assembled word; mem_byte_w_en SHALL be 4'b0000 in every other cycle.
REQ-023 SHALL hold in_ready=1 only in LEN0, LEN1, DATA and CHK, and 0 in WRITE, DONE and ERROR.
REQ-024 SHALL increment word_idx in WRITE, then return to DATA, or leave after word N-1 (to CHK with the macro, to DONE without it).
REQ-025 SHALL keep cpu_hold=1 in every state except DONE, and SHALL release it in the same cycle done rises.
REQ-026 SHALL assert error=1 and keep cpu_hold=1 while in ERROR.
REQ-027 SHALL, on restart=1 in DONE or ERROR, clear word_idx and the assembly register and go to LEN0 on the next edge.
REQ-028 SHALL ignore restart in all other states.
REQ-029 SHALL stall with state unchanged whenever in_valid=0; a stall SHALL never time out.
REQ-030 SHALL write a word at most once; word_idx SHALL never exceed N.

Reset
REQ-031 SHALL, while rst=0, force state LEN0, word_idx=0, N=0, checksum=0, in_ready=0, mem_byte_w_en=0, mem_wr_addr=0, mem_wr_data=0, done=0, error=0 and cpu_hold=1.
REQ-032 SHALL, on rst=0 mid-load, abandon the load without any further write; words already written stay in memory.
REQ-033 SHALL drive in_ready=1 from the first edge after rst rises.

Configuration
REQ-034 SHALL, with PROG_LOADER_CHECKSUM_EN defined, XOR every accepted byte (header and payload) into an 8-bit checksum and expect one trailing byte in CHK.
REQ-035 SHALL, with the macro defined, go to DONE when the trailing byte equals the checksum and to ERROR when it does not.
REQ-036 SHALL, without the macro, contain no CHK state and no checksum logic.

Structure
REQ-037 SHALL take the state encoding enum, the byte-enable constant 4'b1111 and the header length (2) from the shared package cpu_pkg.
REQ-038 SHALL contain one sub-module, word_assembler: a byte counter, shift register and word-complete flag.

Verification
REQ-039 Bytes 01 00 13 00 00 00 -> one write: addr 0x000, data 0x00000013, mem_byte_w_en 4'b1111, then done=1 and cpu_hold=0.
REQ-040 N=2, words 0xDEADBEEF and 0x00100093, with in_valid gaps -> writes at addr 0x000 and 0x004, in_ready=0 in both WRITE cycles, then done=1.
REQ-041 Header 01 04 (N=1025) -> error=1, no write, cpu_hold=1.
REQ-042 rst=0 after the 2nd payload byte, then a full reload -> no write before reset, correct write after the reload.
REQ-043 With the macro: N=1, word 0x00000013, trailing byte 0x12 -> done=1; trailing byte 0x13 -> error=1; then restart -> state LEN0.
REQ-044 Header 00 00 -> done=1 with no write and no payload consumed (with the macro, after trailing checksum byte 0x00).
